// File: rtl/id_imm_ctrl.sv
// Decode-stage controller: 2-entry skid buffer between fetch and the immediate generator.
// Each accepted instruction is classified into an immgen select and an illegal flag.
module id_imm_ctrl #(
  parameter bit          EN_FP = 1'b1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_inst_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_inst_o,
  output logic [2:0]       out_imm_op_o,
  output logic             out_illegal_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [2:0] ImmI   = 3'b000;
  localparam logic [2:0] ImmS   = 3'b001;
  localparam logic [2:0] ImmB   = 3'b010;
  localparam logic [2:0] ImmU   = 3'b011;
  localparam logic [2:0] ImmJ   = 3'b100;
  localparam logic [2:0] ImmR   = 3'b101;
  localparam logic [2:0] ImmF   = 3'b110;
  localparam logic [2:0] ImmBad = 3'b111;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e      state_q;
  logic [31:0] sec_inst_q;
  logic [2:0]  sec_op_q;
  logic        sec_ill_q;

  logic [2:0]  dec_op;
  logic        dec_ill;
  logic        is_fp;
  logic        acc;
  logic        pop;

  assign acc = in_valid_i & in_ready_o;
  assign pop = out_valid_o & out_ready_i;

  // Opcodes not ending in 2'b11 never match a listed pattern, so they fall to default.
  always_comb begin
    dec_op = ImmBad;
    is_fp  = 1'b0;
    unique case (in_inst_i[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: dec_op = ImmI;
      7'b0000111: begin dec_op = ImmI; is_fp = 1'b1; end
      7'b0100011: dec_op = ImmS;
      7'b0100111: begin dec_op = ImmS; is_fp = 1'b1; end
      7'b1100011: dec_op = ImmB;
      7'b0110111, 7'b0010111: dec_op = ImmU;
      7'b1101111: dec_op = ImmJ;
      7'b0110011: dec_op = ImmR;
      7'b1010011, 7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin
        dec_op = ImmR;
        is_fp  = 1'b1;
      end
      7'b0001011: begin dec_op = ImmF; is_fp = 1'b1; end
      default: dec_op = ImmBad;
    endcase
    if (is_fp && !EN_FP) dec_op = ImmBad;
    dec_ill = (dec_op == ImmBad);
  end

  // Head entry lives directly in the output registers; the second entry is sec_*.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StEmpty;
      in_ready_o    <= 1'b1;
      out_valid_o   <= 1'b0;
      out_inst_o    <= '0;
      out_imm_op_o  <= ImmR;
      out_illegal_o <= 1'b0;
      sec_inst_q    <= '0;
      sec_op_q      <= ImmR;
      sec_ill_q     <= 1'b0;
      stall_cnt_o   <= '0;
    end else begin
      if (flush_i) begin
        state_q       <= StEmpty;
        in_ready_o    <= 1'b1;
        out_valid_o   <= 1'b0;
        out_imm_op_o  <= ImmR;
        out_illegal_o <= 1'b0;
      end else begin
        unique case (state_q)
          StEmpty: begin
            if (acc) begin
              state_q       <= StOne;
              out_valid_o   <= 1'b1;
              out_inst_o    <= in_inst_i;
              out_imm_op_o  <= dec_op;
              out_illegal_o <= dec_ill;
            end
          end
          StOne: begin
            if (acc && !pop) begin
              state_q    <= StTwo;
              in_ready_o <= 1'b0;
              sec_inst_q <= in_inst_i;
              sec_op_q   <= dec_op;
              sec_ill_q  <= dec_ill;
            end else if (acc && pop) begin
              out_inst_o    <= in_inst_i;
              out_imm_op_o  <= dec_op;
              out_illegal_o <= dec_ill;
            end else if (pop) begin
              state_q       <= StEmpty;
              out_valid_o   <= 1'b0;
              out_imm_op_o  <= ImmR;
              out_illegal_o <= 1'b0;
            end
          end
          StTwo: begin
            if (pop) begin
              state_q       <= StOne;
              in_ready_o    <= 1'b1;
              out_inst_o    <= sec_inst_q;
              out_imm_op_o  <= sec_op_q;
              out_illegal_o <= sec_ill_q;
            end
          end
          default: begin
            state_q       <= StEmpty;
            in_ready_o    <= 1'b1;
            out_valid_o   <= 1'b0;
            out_imm_op_o  <= ImmR;
            out_illegal_o <= 1'b0;
          end
        endcase
      end
      // Flush does not clear the stall counter.
      if (out_valid_o && !out_ready_i && (stall_cnt_o != {CNT_W{1'b1}})) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule
